status_register_bank: RTL and testbench

Parametrised successor to the single-bank NZCV status register. It holds the current program status (flags plus processor mode) and one banked saved-status word per privileged mode. It supports ALU flag updates, masked software writes (MSR-style), exception entry (save and switch mode) and exception return (restore). It sits between the EXE stage and the condition-check and control logic, and all state updates on the falling clock edge.

---
 rtl/status_register_bank.sv | 83 ++++++++
 tb/tb_status_register_bank.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/status_register_bank.sv
// rtl/status_register_bank.sv - current flags/mode plus one banked saved-status word per privileged mode
// All state advances on the falling edge so posedge consumers see settled status.
module status_register_bank #(
  parameter int FLAG_W    = 4,
  parameter int NUM_MODES = 4,
  parameter int MODE_W    = $clog2(NUM_MODES)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_en,
  input  logic [FLAG_W-1:0]        flags_in,
  input  logic                     msr_en,
  input  logic [FLAG_W-1:0]        msr_mask,
  input  logic [FLAG_W-1:0]        msr_data,
  input  logic                     exc_en,
  input  logic [MODE_W-1:0]        exc_mode,
  input  logic                     ret_en,
  output logic [FLAG_W-1:0]        flags_out,
  output logic [MODE_W-1:0]        mode_out,
  output logic [FLAG_W+MODE_W-1:0] spsr_out,
  output logic                     err
);

  localparam int SPSR_W = FLAG_W + MODE_W;
  localparam logic [31:0] NUM_MODES_U = NUM_MODES;

  logic [FLAG_W-1:0] flags_q, flags_d;
  logic [MODE_W-1:0] mode_q, mode_d;
  logic [SPSR_W-1:0] spsr_q [NUM_MODES];
  logic              err_q, err_d;
  logic              exc_legal, exc_illegal;
  logic              ret_legal, ret_illegal;

  always_comb begin
    exc_legal   = exc_en && (exc_mode != '0) && (32'(exc_mode) < NUM_MODES_U);
    exc_illegal = exc_en && !exc_legal;
    // A legal exception swallows the return request entirely, including its error.
    ret_legal   = !exc_legal && ret_en && (mode_q != '0);
    ret_illegal = !exc_legal && ret_en && (mode_q == '0);
    err_d       = exc_illegal || ret_illegal;

    flags_d = flags_q;
    mode_d  = mode_q;
    if (exc_legal) begin
      mode_d = exc_mode;
    end else if (ret_legal) begin
      {flags_d, mode_d} = spsr_q[mode_q];
    end else begin
      for (int i = 0; i < FLAG_W; i++) begin
        if (msr_en && msr_mask[i]) begin
          flags_d[i] = msr_data[i];
        end else if (s_en) begin
          flags_d[i] = flags_in[i];
        end
      end
    end
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
      mode_q  <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < NUM_MODES; i++) begin
        spsr_q[i] <= '0;
      end
    end else begin
      flags_q <= flags_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
      if (exc_legal) begin
        spsr_q[exc_mode] <= {flags_q, mode_q};
      end
    end
  end

  // User mode has no bank; its entry is never written but is masked anyway.
  assign spsr_out  = (mode_q == '0) ? '0 : spsr_q[mode_q];
  assign flags_out = flags_q;
  assign mode_out  = mode_q;
  assign err       = err_q;

endmodule

// File: tb/tb_status_register_bank.sv
// tb/tb_status_register_bank.sv - scoreboard bench for status_register_bank
module tb_status_register_bank;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       s_en = 1'b0;
  logic [3:0] flags_in = '0;
  logic       msr_en = 1'b0;
  logic [3:0] msr_mask = '0;
  logic [3:0] msr_data = '0;
  logic       exc_en = 1'b0;
  logic [1:0] exc_mode = '0;
  logic       ret_en = 1'b0;
  logic [3:0] flags_out;
  logic [1:0] mode_out;
  logic [5:0] spsr_out;
  logic       err;

  typedef struct packed {
    logic       s;
    logic [3:0] fi;
    logic       m;
    logic [3:0] mk;
    logic [3:0] md;
    logic       e;
    logic [1:0] em;
    logic       r;
  } stim_t;

  typedef struct packed {
    logic [3:0] f;
    logic [1:0] mode;
    logic [5:0] sp;
    logic       er;
  } obs_t;

  obs_t sb[$];
  int   passed = 0;
  int   total = 0;

  status_register_bank dut (
    .clk(clk), .rst_n(rst_n), .s_en(s_en), .flags_in(flags_in),
    .msr_en(msr_en), .msr_mask(msr_mask), .msr_data(msr_data),
    .exc_en(exc_en), .exc_mode(exc_mode), .ret_en(ret_en),
    .flags_out(flags_out), .mode_out(mode_out), .spsr_out(spsr_out), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  function automatic obs_t obs();
    return {flags_out, mode_out, spsr_out, err};
  endfunction

  function automatic stim_t mk(input logic s, input logic [3:0] fi, input logic m,
                               input logic [3:0] msk, input logic [3:0] md,
                               input logic e, input logic [1:0] em, input logic r);
    return {s, fi, m, msk, md, e, em, r};
  endfunction

  // Inputs change just after a falling edge and are sampled on the next one.
  task automatic drive(input stim_t st);
    {s_en, flags_in, msr_en, msr_mask, msr_data, exc_en, exc_mode, ret_en} = st;
    @(negedge clk);
    #1;
    {s_en, flags_in, msr_en, msr_mask, msr_data, exc_en, exc_mode, ret_en} = '0;
  endtask

  task automatic test_reset();
    obs_t e;
    for (int i = 0; i < 2; i++) begin
      sb.push_back('0);
      @(negedge clk);
      #1;
      e = sb.pop_front();
      total++;
      if (obs() !== e) $display("FAIL reset_hold[%0d]: got %b required %b", i, obs(), e);
      else passed++;
    end
    rst_n = 1'b1;
    sb.push_back({4'b1010, 2'd0, 6'b0, 1'b0});
    drive(mk(1, 4'b1010, 0, 4'b0, 4'b0, 0, 2'd0, 0));
    e = sb.pop_front();
    total++;
    if (obs() !== e) $display("FAIL reset_release_alu: got %b required %b", obs(), e);
    else passed++;
  endtask

  task automatic test_merge();
    obs_t e;
    sb.push_back({4'b0101, 2'd0, 6'b0, 1'b0});
    drive(mk(1, 4'b0001, 1, 4'b1100, 4'b0111, 0, 2'd0, 0));
    e = sb.pop_front();
    total++;
    if (obs() !== e) $display("FAIL msr_merge: got %b required %b", obs(), e);
    else passed++;
  endtask

  task automatic test_nested();
    stim_t st [6];
    obs_t  ex [6];
    obs_t  e;
    st[0] = mk(0, 4'b0, 1, 4'b1111, 4'b0110, 0, 2'd0, 0); ex[0] = {4'b0110, 2'd0, 6'b000000, 1'b0};
    st[1] = mk(0, 4'b0, 0, 4'b0,    4'b0,    1, 2'd2, 0); ex[1] = {4'b0110, 2'd2, 6'b011000, 1'b0};
    st[2] = mk(0, 4'b0, 1, 4'b1111, 4'b1111, 0, 2'd0, 0); ex[2] = {4'b1111, 2'd2, 6'b011000, 1'b0};
    st[3] = mk(0, 4'b0, 0, 4'b0,    4'b0,    1, 2'd3, 0); ex[3] = {4'b1111, 2'd3, 6'b111110, 1'b0};
    st[4] = mk(0, 4'b0, 0, 4'b0,    4'b0,    0, 2'd0, 1); ex[4] = {4'b1111, 2'd2, 6'b011000, 1'b0};
    st[5] = mk(0, 4'b0, 0, 4'b0,    4'b0,    0, 2'd0, 1); ex[5] = {4'b0110, 2'd0, 6'b000000, 1'b0};
    for (int i = 0; i < 6; i++) begin
      sb.push_back(ex[i]);
      drive(st[i]);
      e = sb.pop_front();
      total++;
      if (obs() !== e) $display("FAIL nested[%0d]: got %b required %b", i, obs(), e);
      else passed++;
    end
  endtask

  task automatic test_priority();
    stim_t st [3];
    obs_t  ex [3];
    obs_t  e;
    st[0] = mk(0, 4'b0,    1, 4'b1111, 4'b0011, 0, 2'd0, 0); ex[0] = {4'b0011, 2'd0, 6'b000000, 1'b0};
    st[1] = mk(1, 4'b1000, 0, 4'b0,    4'b0,    1, 2'd1, 1); ex[1] = {4'b0011, 2'd1, 6'b001100, 1'b0};
    st[2] = mk(0, 4'b0,    0, 4'b0,    4'b0,    0, 2'd0, 1); ex[2] = {4'b0011, 2'd0, 6'b000000, 1'b0};
    for (int i = 0; i < 3; i++) begin
      sb.push_back(ex[i]);
      drive(st[i]);
      e = sb.pop_front();
      total++;
      if (obs() !== e) $display("FAIL priority[%0d]: got %b required %b", i, obs(), e);
      else passed++;
    end
  endtask

  task automatic test_illegal();
    stim_t st [4];
    obs_t  ex [4];
    obs_t  e;
    st[0] = mk(0, 4'b0,    0, 4'b0, 4'b0, 0, 2'd0, 1); ex[0] = {4'b0011, 2'd0, 6'b0, 1'b1};
    st[1] = mk(0, 4'b0,    0, 4'b0, 4'b0, 0, 2'd0, 0); ex[1] = {4'b0011, 2'd0, 6'b0, 1'b0};
    st[2] = mk(1, 4'b0100, 0, 4'b0, 4'b0, 1, 2'd0, 0); ex[2] = {4'b0100, 2'd0, 6'b0, 1'b1};
    st[3] = mk(0, 4'b0,    0, 4'b0, 4'b0, 0, 2'd0, 0); ex[3] = {4'b0100, 2'd0, 6'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      sb.push_back(ex[i]);
      drive(st[i]);
      e = sb.pop_front();
      total++;
      if (obs() !== e) $display("FAIL illegal[%0d]: got %b required %b", i, obs(), e);
      else passed++;
    end
  endtask

  task automatic test_same_mode();
    stim_t st [3];
    obs_t  ex [3];
    obs_t  e;
    st[0] = mk(0, 4'b0, 0, 4'b0, 4'b0, 1, 2'd3, 0); ex[0] = {4'b0100, 2'd3, 6'b010000, 1'b0};
    st[1] = mk(0, 4'b0, 0, 4'b0, 4'b0, 1, 2'd3, 0); ex[1] = {4'b0100, 2'd3, 6'b010011, 1'b0};
    st[2] = mk(0, 4'b0, 0, 4'b0, 4'b0, 0, 2'd0, 1); ex[2] = {4'b0100, 2'd3, 6'b010011, 1'b0};
    for (int i = 0; i < 3; i++) begin
      sb.push_back(ex[i]);
      drive(st[i]);
      e = sb.pop_front();
      total++;
      if (obs() !== e) $display("FAIL same_mode[%0d]: got %b required %b", i, obs(), e);
      else passed++;
    end
  endtask

  task automatic test_reset_mid_op();
    obs_t e;
    exc_en   = 1'b1;
    exc_mode = 2'd1;
    #2;
    rst_n = 1'b0;
    #1;
    sb.push_back('0);
    e = sb.pop_front();
    total++;
    if (obs() !== e) $display("FAIL reset_immediate: got %b required %b", obs(), e);
    else passed++;
    @(negedge clk);
    #1;
    sb.push_back('0);
    e = sb.pop_front();
    total++;
    if (obs() !== e) $display("FAIL reset_through_edge: got %b required %b", obs(), e);
    else passed++;
    exc_en   = 1'b0;
    exc_mode = 2'd0;
    rst_n    = 1'b1;
    sb.push_back('0);
    drive(mk(0, 4'b0, 0, 4'b0, 4'b0, 0, 2'd0, 0));
    e = sb.pop_front();
    total++;
    if (obs() !== e) $display("FAIL reset_release_idle: got %b required %b", obs(), e);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_merge();
    test_nested();
    test_priority();
    test_illegal();
    test_same_mode();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
